// File: rtl/game_flow_controller.sv
// Game flow FSM: debounced start/pause/quit key actions drive START/PLAY/PAUSE/OVER.
// Optional macro GAME_FLOW_PAUSE_EN builds the PAUSE state and the pause/quit debouncers.
module game_flow_controller #(
  parameter int NUM_KEYS = 6,
  parameter int DEB_WIDTH = 4,
  parameter logic [DEB_WIDTH-1:0] DEB_THRESHOLD = 4'hF,
  parameter int MAX_LIVES = 3,
  parameter logic [7:0] START_CODE = 8'h2C,
  parameter logic [7:0] PAUSE_CODE = 8'h13,
  parameter logic [7:0] QUIT_CODE = 8'h15,
  localparam int LIVES_W = $clog2(MAX_LIVES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*NUM_KEYS-1:0] key_codes,
  input  logic                  hit,
  input  logic                  level_done,
  output logic [2:0]            state_out,
  output logic [LIVES_W-1:0]    lives_out,
  output logic [7:0]            level_out,
  output logic                  new_game,
  output logic                  game_active
);

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_OVER  = 3'd3;
`ifdef GAME_FLOW_PAUSE_EN
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam int NUM_ACT = 3;
`else
  localparam int NUM_ACT = 1;
`endif

  localparam logic [DEB_WIDTH:0] TH = {1'b0, DEB_THRESHOLD};

  logic [NUM_ACT-1:0] press;

  // Action 0 = start, 1 = pause, 2 = quit; each gets its own debouncer.
  generate
    for (genvar gi = 0; gi < NUM_ACT; gi++) begin : g_act
      localparam logic [7:0] CODE = (gi == 0) ? START_CODE :
                                    (gi == 1) ? PAUSE_CODE : QUIT_CODE;
      logic                 raw;
      logic                 stable_reg;
      logic                 clean_reg;
      logic                 clean_d_reg;
      logic                 press_reg;
      logic [DEB_WIDTH-1:0] cnt_reg;

      always_comb begin
        raw = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
          if (key_codes[8*k +: 8] == CODE) raw = 1'b1;
        end
      end

      // clean follows stable on the same edge the counter reaches the threshold.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stable_reg  <= 1'b0;
          clean_reg   <= 1'b0;
          clean_d_reg <= 1'b0;
          press_reg   <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          if (raw != stable_reg) begin
            cnt_reg    <= '0;
            stable_reg <= raw;
          end else begin
            if ({1'b0, cnt_reg} < TH) cnt_reg <= cnt_reg + DEB_WIDTH'(1);
            if (({1'b0, cnt_reg} + (DEB_WIDTH+1)'(1)) >= TH) clean_reg <= stable_reg;
          end
          clean_d_reg <= clean_reg;
          press_reg   <= clean_reg & ~clean_d_reg;
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic start_press;
  assign start_press = press[0];
`ifdef GAME_FLOW_PAUSE_EN
  logic pause_press;
  logic quit_press;
  assign pause_press = press[1];
  assign quit_press  = press[2];
`endif

  logic [2:0]         state_reg;
  logic [LIVES_W-1:0] lives_reg;
  logic [7:0]         level_reg;
  logic               new_game_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_START;
      lives_reg    <= LIVES_W'(MAX_LIVES);
      level_reg    <= 8'd0;
      new_game_reg <= 1'b0;
    end else begin
      new_game_reg <= 1'b0;
      case (state_reg)
        S_START: begin
          if (start_press) begin
            state_reg    <= S_PLAY;
            lives_reg    <= LIVES_W'(MAX_LIVES);
            level_reg    <= 8'd1;
            new_game_reg <= 1'b1;
          end
        end
        S_PLAY: begin
          // hit has priority over level_done, and losing the last life beats pausing.
          if (hit) begin
            if (lives_reg != '0) lives_reg <= lives_reg - LIVES_W'(1);
          end else if (level_done && level_reg != 8'hFF) begin
            level_reg <= level_reg + 8'd1;
          end
          if (hit && lives_reg <= LIVES_W'(1)) state_reg <= S_OVER;
`ifdef GAME_FLOW_PAUSE_EN
          else if (pause_press) state_reg <= S_PAUSE;
`endif
        end
`ifdef GAME_FLOW_PAUSE_EN
        S_PAUSE: begin
          if (quit_press) state_reg <= S_START;
          else if (pause_press) state_reg <= S_PLAY;
        end
`endif
        S_OVER: begin
          if (start_press) state_reg <= S_START;
        end
        default: state_reg <= S_START;
      endcase
    end
  end

  assign state_out   = state_reg;
  assign lives_out   = lives_reg;
  assign level_out   = level_reg;
  assign new_game    = new_game_reg;
  assign game_active = (state_reg == S_PLAY);

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with a scoreboard of expected transitions.
module tb_game_flow_controller;

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_OVER  = 3'd3;
  localparam logic [7:0] K_SP = 8'h2C;
  localparam logic [7:0] K_P  = 8'h13;
  localparam logic [7:0] K_R  = 8'h15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] key_codes = '0;
  logic        hit = 1'b0;
  logic        level_done = 1'b0;
  logic [2:0]  state_out;
  logic [1:0]  lives_out;
  logic [7:0]  level_out;
  logic        new_game;
  logic        game_active;

  int errors = 0;
  int checks = 0;
  int ng_count = 0;

  typedef struct {
    logic [2:0] st;
    logic [1:0] lives;
    logic [7:0] level;
    int         lat;
    int         ng;
  } exp_t;

  exp_t sb[$];

  game_flow_controller dut (
    .clk(clk), .reset(reset), .key_codes(key_codes), .hit(hit),
    .level_done(level_done), .state_out(state_out), .lives_out(lives_out),
    .level_out(level_out), .new_game(new_game), .game_active(game_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (new_game === 1'b1) ng_count++;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic h, input logic ld);
    hit = h;
    level_done = ld;
    step();
    hit = 1'b0;
    level_done = 1'b0;
  endtask

  // Drive up to two key codes, wait for the state change, then compare with the scoreboard.
  task automatic press_check(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                             input exp_t e);
    logic [2:0] prev;
    int lat;
    int ng0;
    exp_t x;
    prev = state_out;
    ng0 = ng_count;
    sb.push_back(e);
    key_codes[7:0] = c0;
    key_codes[15:8] = c1;
    lat = 0;
    while (state_out === prev && lat < 40) begin
      step();
      lat++;
    end
    x = sb.pop_front();
    check({tag, "_lat"}, 32'(lat), 32'(x.lat));
    check({tag, "_state"}, 32'(state_out), 32'(x.st));
    check({tag, "_lives"}, 32'(lives_out), 32'(x.lives));
    check({tag, "_level"}, 32'(level_out), 32'(x.level));
    check({tag, "_newgame_now"}, 32'(new_game), (x.ng != 0) ? 32'd1 : 32'd0);
    repeat (6) step();
    key_codes = '0;
    repeat (25) step();
    check({tag, "_newgame_cnt"}, 32'(ng_count - ng0), 32'(x.ng));
    check({tag, "_state_hold"}, 32'(state_out), 32'(x.st));
    $display("press %s: lat=%0d state=%0d lives=%0d level=%0d", tag, lat, state_out, lives_out, level_out);
  endtask

  initial begin
    int ng0;
    int lat;
    step();
    step();
    check("rst_state", 32'(state_out), 32'(S_START));
    check("rst_lives", 32'(lives_out), 32'd3);
    check("rst_level", 32'(level_out), 32'd0);
    check("rst_newgame", 32'(new_game), 32'd0);
    check("rst_active", 32'(game_active), 32'd0);
    reset = 1'b0;
    repeat (5) step();

    // Bouncing key never holds long enough to debounce.
    ng0 = ng_count;
    for (int i = 0; i < 100; i++) begin
      key_codes[23:16] = ((i / 8) % 2 == 0) ? K_SP : 8'h00;
      step();
    end
    key_codes = '0;
    repeat (20) step();
    check("bounce_state", 32'(state_out), 32'(S_START));
    check("bounce_newgame", 32'(ng_count - ng0), 32'd0);
    $display("bounce: state=%0d", state_out);

    press_check("start1", K_SP, 8'h00, exp_t'{S_PLAY, 2'd3, 8'd1, 18, 1});
    check("play_active", 32'(game_active), 32'd1);

    for (int i = 2; i <= 4; i++) begin
      pulse(1'b0, 1'b1);
      check("level_inc", 32'(level_out), 32'(i));
      repeat (4) step();
    end

    pulse(1'b1, 1'b1);
    check("hitlvl_lives", 32'(lives_out), 32'd2);
    check("hitlvl_level", 32'(level_out), 32'd4);
    repeat (4) step();
    pulse(1'b1, 1'b0);
    check("hit2_lives", 32'(lives_out), 32'd1);
    check("hit2_state", 32'(state_out), 32'(S_PLAY));
    repeat (4) step();
    pulse(1'b1, 1'b0);
    check("hit3_lives", 32'(lives_out), 32'd0);
    check("hit3_state", 32'(state_out), 32'(S_OVER));
    check("hit3_active", 32'(game_active), 32'd0);
    repeat (4) step();
    pulse(1'b1, 1'b0);
    check("hit4_lives", 32'(lives_out), 32'd0);
    check("hit4_state", 32'(state_out), 32'(S_OVER));
    pulse(1'b0, 1'b1);
    check("over_level", 32'(level_out), 32'd4);
    $display("hits: lives=%0d state=%0d level=%0d", lives_out, state_out, level_out);

    press_check("over_start", K_SP, 8'h00, exp_t'{S_START, 2'd0, 8'd4, 18, 0});
    press_check("start2", K_SP, 8'h00, exp_t'{S_PLAY, 2'd3, 8'd1, 18, 1});

    level_done = 1'b1;
    repeat (254) step();
    level_done = 1'b0;
    check("level_255", 32'(level_out), 32'd255);
    pulse(1'b0, 1'b1);
    check("level_sat", 32'(level_out), 32'd255);
    $display("level saturate: level=%0d", level_out);

`ifdef GAME_FLOW_PAUSE_EN
    press_check("pause", K_P, 8'h00, exp_t'{S_PAUSE, 2'd3, 8'd255, 18, 0});
    pulse(1'b1, 1'b0);
    check("pause_hit_ignored", 32'(lives_out), 32'd3);
    press_check("quit_pause", K_R, K_P, exp_t'{S_START, 2'd3, 8'd255, 18, 0});
    press_check("start3", K_SP, 8'h00, exp_t'{S_PLAY, 2'd3, 8'd1, 18, 1});
`else
    key_codes[7:0] = K_P;
    repeat (30) step();
    key_codes = '0;
    repeat (20) step();
    check("nopause_state", 32'(state_out), 32'(S_PLAY));
    $display("pause disabled: state=%0d", state_out);
`endif

    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      repeat (4) step();
    end
    check("over_again", 32'(state_out), 32'(S_OVER));

    // Reset while a key is held: immediate START, then one press after release.
    key_codes[31:24] = K_SP;
    repeat (3) step();
    reset = 1'b1;
    #1;
    check("async_rst_state", 32'(state_out), 32'(S_START));
    check("async_rst_lives", 32'(lives_out), 32'd3);
    check("async_rst_level", 32'(level_out), 32'd0);
    step();
    reset = 1'b0;
    ng0 = ng_count;
    lat = 0;
    while (state_out === S_START && lat < 40) begin
      step();
      lat++;
    end
    check("held_lat", 32'(lat), 32'd18);
    check("held_state", 32'(state_out), 32'(S_PLAY));
    check("held_lives", 32'(lives_out), 32'd3);
    check("held_level", 32'(level_out), 32'd1);
    repeat (30) step();
    check("held_one_press", 32'(ng_count - ng0), 32'd1);
    key_codes = '0;
    $display("reset held key: lat=%0d state=%0d", lat, state_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
